// File: rtl/tts_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
// Holds the FSM state encoding plus the table and settle-counter width functions.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic int TBL_W(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int CNT_W(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/truth_table_scanner_settle_counter.sv
// Settle-time counter: counts held cycles of the current vector.
// Ports: clk, rst_n, clear_i (restart at 0), enable_i (advance), expire_o (count == SETTLE-1).
module settle_counter
    import tts_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = CNT_W(SETTLE);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: walks dut_in through 0..2**N_IN-1, waits SETTLE
// cycles per vector, samples dut_out into table_o[k]. Ports: clk, rst_n, start,
// dut_in, dut_out, table_o (captured table), busy (scan active), done (1-cycle pulse).
module truth_table_scanner
    import tts_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic [N_IN-1:0]           dut_in,
    input  logic                      dut_out,
    output logic [TBL_W(N_IN)-1:0]    table_o,
    output logic                      busy,
    output logic                      done
);

    localparam int TW = TBL_W(N_IN);
    // idx is one bit wider than dut_in so the terminal compare never wraps
    localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(TW - 1);

    state_e          state_q;
    state_e          state_d;
    logic [N_IN:0]   idx_q;
    logic [N_IN:0]   idx_d;
    logic [TW-1:0]   tbl_q;
    logic [TW-1:0]   tbl_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            expire;

    settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .expire_o (expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tbl_d   = tbl_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tbl_d   = '0;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (expire) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            SAMPLE: begin
                // dut_out is captured untouched, X/Z included
                tbl_d[idx_q[N_IN-1:0]] = dut_out;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_clr = 1'b1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tbl_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tbl_q   <= tbl_d;
        end
    end

    // dut_in comes straight from the index register, so it is glitch-free
    assign dut_in  = idx_q[N_IN-1:0];
    assign table_o = tbl_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized self-checking bench for truth_table_scanner.
// Two instances: default SETTLE=2 and SETTLE=1, both N_IN=3.
module tb_truth_table_scanner;

    localparam int S  = 2;
    localparam int NV = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_out;
    logic [7:0] tbl;
    logic       busy;
    logic       done;

    logic       start2;
    logic [2:0] dut_in2;
    logic       dut_out2;
    logic [7:0] tbl2;
    logic       busy2;
    logic       done2;

    int         mode;
    logic [7:0] rnd_tt;
    int         n_chk;
    int         n_bad;

    truth_table_scanner #(.N_IN(3), .SETTLE(S)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .dut_in  (dut_in),
        .dut_out (dut_out),
        .table_o (tbl),
        .busy    (busy),
        .done    (done)
    );

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .dut_in  (dut_in2),
        .dut_out (dut_out2),
        .table_o (tbl2),
        .busy    (busy2),
        .done    (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // network functions evaluated arithmetically on the vector number
    function automatic logic net(input int m, input int k, input logic [7:0] tt);
        int pc;
        pc = 0;
        for (int i = 0; i < 3; i++) pc += (k >> i) & 1;
        case (m)
            0:       return logic'(pc % 2);
            1:       return logic'(((k / 2) % 2) != ((k / 4) % 2));
            2:       return 1'b0;
            3:       return logic'(k == 7);
            default: return tt[k];
        endcase
    endfunction

    function automatic logic [7:0] model_tbl(input int m, input logic [7:0] tt);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NV; k++) r[k] = net(m, k, tt);
        return r;
    endfunction

    always_comb dut_out  = net(mode, int'(dut_in), rnd_tt);
    always_comb dut_out2 = net(0, int'(dut_in2), rnd_tt);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic scan(input string tag, input int m, input bit poke);
        int   dc;
        int   ndone;
        bit   seq_ok;
        bit   busy_ok;
        logic [2:0] din_done;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dc = 0;
        ndone = 0;
        seq_ok = 1'b1;
        busy_ok = 1'b1;
        din_done = '0;
        for (int c = 1; c <= 40 && dc == 0; c++) begin
            @(negedge clk);
            if (poke && c == 5) start = 1'b1;
            if (poke && c == 6) start = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (c < 1 + NV * (S + 1) && int'(dut_in) != (c - 1) / (S + 1)) seq_ok = 1'b0;
            if (done === 1'b1) begin
                dc = c;
                din_done = dut_in;
            end
        end
        chk({tag, "_done_cyc"}, 64'(dc), 64'(1 + NV * (S + 1)));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        chk({tag, "_seq"}, 64'(seq_ok), 64'd1);
        chk({tag, "_din_done"}, 64'(din_done), 64'd7);
        chk({tag, "_table"}, 64'(tbl), 64'(model_tbl(m, rnd_tt)));
        @(negedge clk);
        if (done === 1'b1) ndone++;
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_pulse"}, 64'(ndone), 64'd0);
    endtask

    initial begin
        int dq[$];
        int c2;
        bit gap_ok;
        n_chk  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 0;
        rnd_tt = '0;
        #12;
        chk("rst_table", 64'(tbl), 64'd0);
        chk("rst_din", 64'(dut_in), 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_quiet", {59'd0, busy, done, dut_in}, 64'd0);

        scan("parity", 0, 1'b0);
        chk("parity_const", 64'(tbl), 64'h96);

        // table persists and no scan starts without a start request
        mode = 1;
        c2 = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) c2++;
        end
        chk("persist_table", 64'(tbl), 64'h96);
        chk("persist_quiet", 64'(c2), 64'd0);

        scan("bxc", 1, 1'b1);
        chk("bxc_const", 64'(tbl), 64'h3C);
        scan("zero", 2, 1'b0);
        scan("and", 3, 1'b0);
        chk("and_const", 64'(tbl), 64'h80);
        for (int r = 0; r < 4; r++) begin
            rnd_tt = 8'($urandom);
            scan($sformatf("rnd%0d", r), 4, ($urandom % 2) == 1);
        end

        // start held high: back-to-back scans with one idle cycle between
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        gap_ok = 1'b0;
        for (int c = 1; c <= 60 && dq.size() < 2; c++) begin
            @(negedge clk);
            if (done === 1'b1) dq.push_back(c);
            if (c == 2 + NV * (S + 1) && busy === 1'b0) gap_ok = 1'b1;
            if (dq.size() == 2) start = 1'b0;
        end
        start = 1'b0;
        chk("b2b_count", 64'(dq.size()), 64'd2);
        chk("b2b_first", 64'(dq.size() > 0 ? dq[0] : 0), 64'd25);
        chk("b2b_second", 64'(dq.size() > 1 ? dq[1] : 0), 64'd51);
        chk("b2b_gap", 64'(gap_ok), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_stop", 64'(busy), 64'd0);

        // reset mid-scan aborts and clears everything asynchronously
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_partial", 64'(tbl), 64'h06);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_table", 64'(tbl), 64'd0);
        chk("mid_din", 64'(dut_in), 64'd0);
        chk("mid_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        c2 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1 || dut_in !== 3'd0) c2++;
        end
        chk("post_rst_quiet", 64'(c2), 64'd0);

        // SETTLE=1 instance: 1 + 8*2 = 17 cycles
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        c2 = 0;
        for (int c = 1; c <= 30 && c2 == 0; c++) begin
            @(negedge clk);
            if (done2 === 1'b1) c2 = c;
        end
        chk("s1_done_cyc", 64'(c2), 64'd17);
        chk("s1_table", 64'(tbl2), 64'(model_tbl(0, rnd_tt)));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture stage that wraps a small combinational gate network, such as the 2:1 mux chains built in this codebase.
- Upstream role: drives every input combination onto the network's input bus in ascending binary order.
- Downstream role: waits a programmable settle time, samples the network's 1-bit output, and assembles the full truth table into a register.
- Reports completion with a one-cycle done pulse, so lab benches and on-board checkers get a self-contained exhaustive scan.

Parameters:
- N_IN, 3, number of network inputs; legal range 1..6. Table width is 2**N_IN.
- SETTLE, 2, clock cycles the vector is held before sampling; legal minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- dut_in  output  N_IN  vector driven to the network; bit 0 = A, bit 1 = B, bit 2 = C.
- dut_out  input  1  network output being sampled.
- table  output  2**N_IN  captured truth table; table[k] = network output for dut_in == k.
- busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive.
- done  output  1  one-cycle pulse when table is complete.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; dut_in, table, idx, cnt all 0; busy = 0; done = 0.
  - Reset mid-scan aborts immediately. No partial table is kept.
- State IDLE:
  - If start == 1: table <= 0, idx <= 0, dut_in <= 0, cnt <= 0, go to WAIT.
  - Otherwise hold. table keeps the last completed result.
- State WAIT:
  - dut_in held stable.
  - If cnt == SETTLE-1, go to SAMPLE. Otherwise cnt <= cnt+1.
- State SAMPLE:
  - table[idx] <= dut_out.
  - If idx == 2**N_IN-1, go to DONE.
  - Otherwise idx <= idx+1, dut_in <= idx+1, cnt <= 0, go to WAIT.
- State DONE:
  - done = 1 and busy = 1 for exactly this cycle.
  - dut_in holds its last vector. Next state is IDLE.
- busy = (state != IDLE). done = (state == DONE). Both are registered-state decodes, so they are glitch-free.
- Latency: done is high in cycle 1 + 2**N_IN*(SETTLE+1) after the start-accept edge. With defaults that is cycle 25.
- start while busy: ignored; the scan is not restarted.
- start held high continuously: after DONE → IDLE, a new scan is accepted on the next edge, giving back-to-back scans with one idle cycle between them.
- Width rules:
  - idx is N_IN+1 bits internally, so the terminal compare cannot wrap.
  - dut_in is the low N_IN bits of idx.
  - cnt is clog2(SETTLE)+1 bits.
- dut_out is sampled as-is. X/Z on dut_out propagates into table; the block does not mask it.

Decomposition:
- Shared package tts_pkg:
  - state enum IDLE=2'd0, WAIT=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - TBL_W function (2**N_IN).
  - CNT_W function (clog2(SETTLE)+1).
- One natural sub-module, settle_counter:
  - inputs: clear, enable.
  - output: expire when the count reaches SETTLE-1.
  - instantiated once.
- FSM, index and table capture stay in the top module.

Test Plan:
- Parity: bench ties dut_out = ^dut_in, defaults, start pulse → done in cycle 25, table = 8'h96, busy high cycles 1..25.
- Mux-network model: dut_out = dut_in[1] ^ dut_in[2] (B xor C) → table = 8'h3C; dut_in visits 0..7 in order, each held 2 cycles before its sample.
- Constants and AND: dut_out tied 0 → table = 8'h00. dut_out = &dut_in → table = 8'h80. Also re-run with SETTLE=1: done at cycle 17.
- Reset mid-scan: assert rst_n=0 at cycle 10 → table, dut_in, busy, done all 0 asynchronously. After release, no activity until a new start.
- start re-asserted at cycle 5 of a scan → ignored, done still at cycle 25. start held high throughout → second scan accepted on the edge after DONE, second done at cycle 51.
- Table persistence: after a parity scan, change the dut_out function without start → table stays 8'h96 and done stays 0.
